// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART RX controller.
`timescale 1ns/1ps
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int unsigned PRESC_8  = 8;
  localparam int unsigned PRESC_16 = 16;
  localparam int unsigned PRESC_32 = 32;

  // Anything other than a supported ratio within the build maximum falls back to 8.
  function automatic int unsigned legal_prescale(input int unsigned p, input int unsigned p_max);
    if ((p == PRESC_8 || p == PRESC_16 || p == PRESC_32) && p <= p_max) return p;
    return PRESC_8;
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter and bit counter; clear has priority over enable.
`timescale 1ns/1ps
module uart_rx_edge_bit_cnt
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE   = 32,
  parameter int unsigned BYTE_WIDTH = 8
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                en,
  input  logic                                clr,
  input  logic [$clog2(PRESCALE):0]           prescale,
  output logic [$clog2(PRESCALE)-1:0]         edge_cnt,
  output logic [$clog2(BYTE_WIDTH):0]         bit_cnt,
  output logic                                bit_done_c
);

  localparam int unsigned CW  = $clog2(PRESCALE);
  localparam int unsigned PW  = CW + 1;
  localparam int unsigned BCW = $clog2(BYTE_WIDTH) + 1;

  assign bit_done_c = en && ({1'b0, edge_cnt} == prescale - PW'(1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (clr) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (en) begin
      if (bit_done_c) begin
        edge_cnt <= '0;
        bit_cnt  <= bit_cnt + BCW'(1);
      end else begin
        edge_cnt <= edge_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detect, mid-bit majority vote, frame sequencing.
// Break detection with a WAIT_IDLE recovery state is built when UART_RX_BREAK_DET_EN is defined.
`timescale 1ns/1ps
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE   = 32,
  parameter int unsigned BYTE_WIDTH = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_rx_in,
  input  logic [$clog2(PRESCALE):0]     i_prescale,
  input  logic                          i_par_en,
  input  logic                          i_par_typ,
  output logic [BYTE_WIDTH-1:0]         o_data,
  output logic                          o_data_valid,
  output logic                          o_par_err,
  output logic                          o_stop_err,
  output logic                          o_break,
  output logic                          o_busy
);

  localparam int unsigned CW  = $clog2(PRESCALE);
  localparam int unsigned PW  = CW + 1;
  localparam int unsigned BCW = $clog2(BYTE_WIDTH) + 1;

  state_t                state, state_nxt;
  logic [PW-1:0]         p_lat;
  logic                  par_en_lat, par_typ_lat;
  logic [CW-1:0]         edge_cnt;
  logic [BCW-1:0]        bit_cnt;
  logic                  bit_done_c, cnt_en_c, cnt_clr_c, frame_start_c;
  logic [PW-1:0]         edge_ext, half;
  logic [2:0]            smp;
  logic                  maj;
  logic [BYTE_WIDTH-1:0] shreg;
  logic                  par_fail;
  logic                  data_valid_c, par_err_c, stop_err_c;
`ifdef UART_RX_BREAK_DET_EN
  logic                  par_zero;
  logic                  is_break_c, break_c;
`endif

  assign edge_ext      = {1'b0, edge_cnt};
  assign half          = p_lat >> 1;
  assign cnt_en_c      = (state != IDLE);
  assign frame_start_c = (state_nxt == START) && (state != START);
`ifdef UART_RX_BREAK_DET_EN
  // In WAIT_IDLE the edge counter measures the current run of idle-high cycles.
  assign cnt_clr_c  = (state_nxt != state) || (state == WAIT_IDLE && !i_rx_in);
  assign is_break_c = (shreg == '0) && par_zero && !maj;
`else
  assign cnt_clr_c  = (state_nxt != state);
`endif

  uart_rx_edge_bit_cnt #(
    .PRESCALE   (PRESCALE),
    .BYTE_WIDTH (BYTE_WIDTH)
  ) u_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .en         (cnt_en_c),
    .clr        (cnt_clr_c),
    .prescale   (p_lat),
    .edge_cnt   (edge_cnt),
    .bit_cnt    (bit_cnt),
    .bit_done_c (bit_done_c)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (!i_rx_in) state_nxt = START;
      START:  if (bit_done_c) state_nxt = maj ? IDLE : DATA;
      DATA:   if (bit_done_c && bit_cnt == BCW'(BYTE_WIDTH - 1))
                state_nxt = par_en_lat ? PARITY : STOP;
      PARITY: if (bit_done_c) state_nxt = STOP;
      STOP: begin
        if (bit_done_c) begin
`ifdef UART_RX_BREAK_DET_EN
          if (is_break_c)    state_nxt = WAIT_IDLE;
          else
`endif
          state_nxt = i_rx_in ? IDLE : START;
        end
      end
`ifdef UART_RX_BREAK_DET_EN
      WAIT_IDLE: if (bit_done_c && i_rx_in) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Frame verdict, decided on the stop bit's completion cycle.
  always_comb begin
    data_valid_c = 1'b0;
    par_err_c    = 1'b0;
    stop_err_c   = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    break_c      = 1'b0;
`endif
    if (state == STOP && bit_done_c) begin
`ifdef UART_RX_BREAK_DET_EN
      if (is_break_c) begin
        break_c = 1'b1;
      end else
`endif
      if (maj) begin
        data_valid_c = !par_fail;
        par_err_c    = par_fail;
      end else begin
        stop_err_c   = 1'b1;
        par_err_c    = par_fail;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      p_lat       <= PW'(PRESC_8);
      par_en_lat  <= 1'b0;
      par_typ_lat <= 1'b0;
      smp         <= '0;
      maj         <= 1'b0;
      shreg       <= '0;
      par_fail    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      par_zero    <= 1'b0;
`endif
    end else begin
      if (frame_start_c) begin
        p_lat       <= PW'(legal_prescale(32'(i_prescale), PRESCALE));
        par_en_lat  <= i_par_en;
        par_typ_lat <= i_par_typ;
        par_fail    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        par_zero    <= 1'b1;
`endif
      end
      // Three samples straddling mid-bit, voted one count later.
      if (cnt_en_c) begin
        if (edge_ext == half - PW'(2))      smp[0] <= i_rx_in;
        else if (edge_ext == half - PW'(1)) smp[1] <= i_rx_in;
        else if (edge_ext == half)          smp[2] <= i_rx_in;
        else if (edge_ext == half + PW'(1))
          maj <= (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
      end
      if (state == DATA && bit_done_c)
        shreg <= {maj, shreg[BYTE_WIDTH-1:1]};
      if (state == PARITY && bit_done_c) begin
        par_fail <= maj != ((^shreg) ^ (par_typ_lat == PAR_ODD));
`ifdef UART_RX_BREAK_DET_EN
        par_zero <= !maj;
`endif
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_par_err    <= 1'b0;
      o_stop_err   <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      if (data_valid_c) o_data <= shreg;
      o_data_valid <= data_valid_c;
      o_par_err    <= par_err_c;
      o_stop_err   <= stop_err_c;
      o_busy       <= (state != IDLE);
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_break <= 1'b0;
    else          o_break <= break_c;
  end
`else
  assign o_break = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomised frame bench for uart_rx_ctrl against a frame-level expectation model.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

  localparam int unsigned PRESCALE = 32;
  localparam int unsigned BW       = 8;
  localparam int unsigned PSW      = $clog2(PRESCALE) + 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           rx;
  logic [PSW-1:0] psc;
  logic           par_en, par_typ;
  logic [BW-1:0]  data;
  logic           data_valid, par_err, stop_err, brk, busy;

  typedef struct {
    int            cyc;
    logic [3:0]    flags;   // {valid, par_err, stop_err, break}
    logic [BW-1:0] data;
  } evt_t;

  evt_t          obs_q[$];
  evt_t          exp_q[$];
  logic          busy_hist[int];
  logic [BW-1:0] model_data;
  int            cyc = 0;
  int            n_checks = 0;
  int            n_fails = 0;

  uart_rx_ctrl #(.PRESCALE(PRESCALE), .BYTE_WIDTH(BW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rx_in      (rx),
    .i_prescale   (psc),
    .i_par_en     (par_en),
    .i_par_typ    (par_typ),
    .o_data       (data),
    .o_data_valid (data_valid),
    .o_par_err    (par_err),
    .o_stop_err   (stop_err),
    .o_break      (brk),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    evt_t e;
    busy_hist[cyc] = busy;
    if (data_valid || par_err || stop_err || brk) begin
      e.cyc   = cyc;
      e.flags = {data_valid, par_err, stop_err, brk};
      e.data  = data;
      obs_q.push_back(e);
    end
  end

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: run exceeded cycle budget at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // What the receiver must report for one frame, and when.
  function automatic logic model_frame(input int t0, input int p, input logic pe, input logic pt,
                                       input logic [BW-1:0] d, input logic pbit, input logic stop_v);
    evt_t e;
    logic pf, is_brk;
    pf     = pe && (pbit != ((^d) ^ pt));
    is_brk = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    is_brk = (d == '0) && (!pe || !pbit) && !stop_v;
`endif
    if (is_brk)      e.flags = 4'b0001;
    else if (stop_v) e.flags = pf ? 4'b0100 : 4'b1000;
    else             e.flags = {1'b0, pf, 2'b10};
    if (e.flags[3]) model_data = d;
    e.data = model_data;
    e.cyc  = t0 + (2 + BW + (pe ? 1 : 0)) * p;
    exp_q.push_back(e);
    return is_brk;
  endfunction

  // Called on a negedge; returns on the negedge ending the stop bit.
  task automatic send_frame(input int p, input logic [PSW-1:0] psc_drv, input logic pe, input logic pt,
                            input logic [BW-1:0] d, input logic par_flip, input logic stop_v,
                            output int t0, output logic is_brk);
    logic bits[$];
    logic pbit;
    pbit = (^d) ^ pt ^ par_flip;
    bits.push_back(1'b0);
    for (int i = 0; i < int'(BW); i++) bits.push_back(d[i]);
    if (pe) bits.push_back(pbit);
    bits.push_back(stop_v);
    psc     = psc_drv;
    par_en  = pe;
    par_typ = pt;
    t0      = cyc + 1;
    is_brk  = model_frame(t0, p, pe, pt, d, pbit, stop_v);
    foreach (bits[i]) begin
      rx = bits[i];
      repeat (p) @(negedge clk);
      if (i == 0) begin
        psc     = PSW'($urandom);
        par_en  = 1'($urandom);
        par_typ = 1'($urandom);
      end
    end
  endtask

  task automatic drain();
    evt_t o, e;
    rx = 1'b1;
    repeat (100) @(negedge clk);
    check("evt_count", obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check("evt_cycle", o.cyc, e.cyc);
      check("evt_flags", o.flags, e.flags);
      check("evt_data", o.data, e.data);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int t0, t1, p, gap;
    logic b;
    logic [PSW-1:0] psc_drv;
    logic [PSW-1:0] ill[5] = '{6'd0, 6'd4, 6'd12, 6'd24, 6'd63};
    logic [BW-1:0] d;
    logic pe, pt, flip, stop_v;

    rst_n = 1'b0; rx = 1'b1; psc = PSW'(8); par_en = 1'b0; par_typ = 1'b0;
    model_data = '0;
    repeat (3) @(negedge clk);
    check("rst_data", data, 0);
    check("rst_valid", data_valid, 0);
    check("rst_par_err", par_err, 0);
    check("rst_stop_err", stop_err, 0);
    check("rst_break", brk, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 8N1, P=8, 0xA5
    send_frame(8, PSW'(8), 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, t0, b);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    check("busy_at_t0", busy_hist[t0], 0);
    check("busy_at_t0p1", busy_hist[t0 + 1], 1);
    check("busy_at_pulse", busy_hist[t0 + 80], 1);
    check("busy_after_pulse", busy_hist[t0 + 81], 0);
    drain();

    // P=16, even parity, wrong parity bit on 0x3C
    send_frame(16, PSW'(16), 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, t0, b);
    drain();

    // Start-bit glitch of 3 cycles
    t0 = cyc + 1;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (15) @(negedge clk);
    check("glitch_busy_during", busy_hist[t0 + 2], 1);
    check("glitch_busy_after", busy_hist[t0 + 9], 0);
    drain();

    // Stop error then clean frame
    send_frame(8, PSW'(8), 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, t0, b);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8, PSW'(8), 1'b0, 1'b0, 8'h11, 1'b0, 1'b1, t0, b);
    drain();

    // Back-to-back 0xFF, 0x00 with no idle gap
    send_frame(8, PSW'(8), 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, t0, b);
    send_frame(8, PSW'(8), 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, t1, b);
    drain();

    // Illegal prescale behaves as 8
    send_frame(8, PSW'(12), 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, t0, b);
    drain();

    // Reset mid-frame
    t0 = cyc + 1;
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (33) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_data", data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_valid", data_valid, 0);
    check("midrst_stop_err", stop_err, 0);
    model_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
    drain();
    send_frame(8, PSW'(8), 1'b0, 1'b0, 8'h7E, 1'b0, 1'b1, t0, b);
    drain();

`ifdef UART_RX_BREAK_DET_EN
    // Line held low for 20 bit periods
    psc = PSW'(8); par_en = 1'b0; par_typ = 1'b0;
    t0 = cyc + 1;
    begin
      evt_t e;
      e.cyc = t0 + 80; e.flags = 4'b0001; e.data = model_data;
      exp_q.push_back(e);
    end
    rx = 1'b0;
    repeat (160) @(negedge clk);
    rx = 1'b1;
    t1 = cyc + 1;
    repeat (20) @(negedge clk);
    check("brk_busy_low_line", busy_hist[t0 + 100], 1);
    check("brk_busy_before_idle", busy_hist[t1 + 7], 1);
    check("brk_busy_idle", busy_hist[t1 + 8], 0);
    drain();
`endif

    // Randomised frames
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0:       p = 8;
        1:       p = 16;
        default: p = 32;
      endcase
      psc_drv = PSW'(p);
      if (p == 8 && $urandom_range(0, 3) == 0) psc_drv = ill[$urandom_range(0, 4)];
      pe     = 1'($urandom);
      pt     = 1'($urandom);
      d      = ($urandom_range(0, 7) == 0) ? '0 : BW'($urandom);
      flip   = ($urandom_range(0, 5) == 0);
      stop_v = ($urandom_range(0, 5) != 0);
      send_frame(p, psc_drv, pe, pt, d, flip, stop_v, t0, b);
      if (b) gap = 2 * p + 2;
      else   gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 20);
      if (gap > 0) begin
        rx = 1'b1;
        repeat (gap) @(negedge clk);
      end
      if (n % 10 == 9) drain();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
